// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks an N_IN-input gate through every input row in
// ascending order, holds each row for SETTLE_CYCLES+1 cycles, samples the gate
// output into a truth-table signature and compares it against EXPECTED.
// Optional build macro: SWEEP_EARLY_ABORT_EN - end the sweep at the first
// mismatching row instead of sampling every row.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for i_start, results held
// S_HOLD   | row vector driven, settle counter running
// S_SAMPLE | row vector still driven, i_dut_out captured
// S_FINISH | o_done pulse, o_dut_in back to 0
module truth_table_sweeper #(
    parameter int                 N_IN          = 3,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECTED      = 8'hBB
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_dut_out,
    output logic [N_IN-1:0]      o_dut_in,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_signature,
    output logic                 o_match,
    output logic                 o_fail_valid,
    output logic [N_IN-1:0]      o_fail_row
);

    localparam int ROWS = 2**N_IN;
    localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [N_IN:0]   ROW_LAST = (N_IN+1)'(ROWS - 1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [N_IN:0]       r_row;
    logic [CW-1:0]       r_cnt;
    logic [ROWS-1:0]     r_signature;
    logic                r_match;
    logic                r_fail_valid;
    logic [N_IN-1:0]     r_fail_row;

    logic [N_IN-1:0]     w_bit_idx;
    logic                w_mismatch;
    logic                w_last_row;
    logic                w_abort;
    logic [ROWS-1:0]     w_sig_next;

    // Row 0 lands in the MSB so the signature reads like the gate's hex name.
    assign w_bit_idx  = IDX_LAST - r_row[N_IN-1:0];
    assign w_mismatch = (i_dut_out != EXPECTED[w_bit_idx]);
    assign w_last_row = (r_row == ROW_LAST);

`ifdef SWEEP_EARLY_ABORT_EN
    assign w_abort = w_mismatch && !r_fail_valid;
`else
    assign w_abort = 1'b0;
`endif

    // Signature with the current sample merged in, so match sees the last row.
    always_comb begin
        w_sig_next            = r_signature;
        w_sig_next[w_bit_idx] = i_dut_out;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a zero settle time skips HOLD entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_last_row || w_abort) begin
                    w_state_next = S_FINISH;
                end else begin
                    w_state_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_HOLD;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Row/settle counters and result capture; results hold until the next start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row        <= '0;
            r_cnt        <= '0;
            r_signature  <= '0;
            r_match      <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row        <= '0;
                        r_cnt        <= '0;
                        r_signature  <= '0;
                        r_match      <= 1'b0;
                        r_fail_valid <= 1'b0;
                        r_fail_row   <= '0;
                    end
                end
                S_HOLD: begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    r_signature <= w_sig_next;
                    r_cnt       <= '0;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_row   <= r_row[N_IN-1:0];
                    end
                    if (w_last_row || w_abort) begin
                        r_row   <= '0;
                        r_match <= (w_sig_next == EXPECTED);
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_dut_in     = r_row[N_IN-1:0];
    assign o_busy       = (r_state == S_HOLD) || (r_state == S_SAMPLE);
    assign o_done       = (r_state == S_FINISH);
    assign o_signature  = r_signature;
    assign o_match      = r_match;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_row   = r_fail_row;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that characterises an N-input combinational logic gate (3-input truth-table modules such as 0xBB).
- Drives the gate's inputs through every input combination in ascending order.
- Waits a programmable settle time, samples the output, and assembles the truth-table signature in hex-name order.
- Compares the signature against an expected value.
- Sits in the test/characterisation harness between a host start strobe and the gate under test.

Parameters:
N_IN, 3, number of gate inputs; rows = 2**N_IN (8 for default).
SETTLE_CYCLES, 4, extra cycles each input vector is held before sampling (0 allowed).
EXPECTED, 8'hBB, expected signature, width 2**N_IN.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
dut_out  input  1  output of gate under test
dut_in  output  N_IN  input vector to gate; MSB = in1, LSB = in(N_IN)
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when sweep ends
signature  output  2**N_IN  captured truth table; bit (2**N_IN-1-row) = dut_out for that row
match  output  1  signature == EXPECTED, valid from done, held
fail_valid  output  1  at least one row mismatched EXPECTED
fail_row  output  N_IN  index of first mismatching row (0 if none)

Behaviour:
- Reset values, applied on any clock edge with rst=1 (including mid-sweep): busy=0, done=0, dut_in=0, signature=0, match=0, fail_valid=0, fail_row=0, state=IDLE, counters=0.
- States:
  - IDLE: waits for start.
  - HOLD: vector driven, settle counter running.
  - SAMPLE: captures dut_out.
  - FINISH: pulses done.
- IDLE -> HOLD on start=1:
  - Next cycle: busy=1, dut_in=0, settle counter=0.
  - signature, match, fail_valid and fail_row clear at the same edge.
- HOLD:
  - Counter increments each cycle.
  - After SETTLE_CYCLES cycles in HOLD, go to SAMPLE.
  - SETTLE_CYCLES=0: HOLD is skipped; go straight to SAMPLE.
- SAMPLE (one cycle; dut_in still = row):
  - Write dut_out into signature bit (2**N_IN-1-row).
  - If dut_out != EXPECTED bit at that position and fail_valid=0: fail_valid<=1, fail_row<=row.
  - If row < 2**N_IN-1: row+1 -> HOLD.
  - Else -> FINISH.
- Each row holds dut_in for exactly SETTLE_CYCLES+1 cycles. Full sweep = 2**N_IN*(SETTLE_CYCLES+1) busy cycles (40 at defaults).
- Row counter is N_IN+1 bits wide; no wrap-around inside a sweep.
- FINISH (one cycle):
  - done=1, busy=0.
  - match = (signature == EXPECTED), computed including the final sample.
  - -> IDLE.
  - dut_in returns to 0.
- After a sweep: signature, match, fail_* hold until the next accepted start or reset.
- start while busy=1 or in FINISH is ignored (not queued).
- start in the same cycle as rst: reset wins.
- done never asserts without a preceding busy period.

Optional Feature:
SWEEP_EARLY_ABORT_EN
- Defined:
  - In SAMPLE, the first mismatching row goes directly to FINISH. done pulses the next cycle with match=0, fail_valid=1, fail_row=row.
  - Unsampled signature bits remain 0.
- Undefined:
  - The sweep always completes all rows.
  - fail_* still record the first mismatch.

Test Plan:
- Gate model = 0xBB function, defaults, start pulse -> busy high 40 cycles; dut_in steps 0..7, each held 5 cycles; done pulse; signature=8'hBB, match=1, fail_valid=0.
- Gate model = 0xBA (row 7 outputs 0) -> signature=8'hBA, match=0, fail_valid=1, fail_row=7.
- SETTLE_CYCLES=0, 0xBB model -> dut_in changes every cycle; busy 8 cycles; signature=8'hBB.
- rst asserted at cycle 17 of sweep -> next cycle all outputs 0, state IDLE. A new start yields a full 40-cycle sweep and a correct signature.
- start re-pulsed at busy cycles 3 and 39 -> ignored; exactly one done. start the cycle after done -> new sweep accepted.
- SWEEP_EARLY_ABORT_EN defined, model mismatching at row 1 (out=1) -> done after 10 busy cycles; fail_row=1, match=0, signature=8'hC0.
